mem_wb_pipe_stage: RTL

//  Parametrised MEM->WB pipeline stage: 2-entry elastic (skid) register on a valid/ready handshake.

---
 rtl/mem_wb_pipe_stage.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mem_wb_pipe_stage.sv
// mem_wb_pipe_stage
//   MEM->WB pipeline stage built as a 2-entry elastic (skid) register on a
//   valid/ready handshake. The head entry drives the writeback outputs; the
//   skid entry absorbs one extra entry while WB stalls. in_ready is taken
//   straight from a flop, so there is no combinational path from out_ready.
//   Optional feature macro: MEM_WB_FWD_EN adds forwarding outputs
//   (fwdValid, fwdReg, fwdData) taken combinationally from the head entry.

module mem_wb_pipe_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  hit,
    input  logic [DATA_W-1:0]     readData,
    input  logic [DATA_W-1:0]     ALUResult,
    input  logic [REG_ADDR_W-1:0] writeReg,
    input  logic                  RegWrite,
    input  logic                  MemToReg,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  hit_OUT,
    output logic [DATA_W-1:0]     readData_OUT,
    output logic [DATA_W-1:0]     ALUResult_OUT,
    output logic [REG_ADDR_W-1:0] writeReg_OUT,
    output logic                  MemToReg_OUT,
    output logic                  RegWrite_OUT
`ifdef MEM_WB_FWD_EN
    ,
    output logic                  fwdValid,
    output logic [REG_ADDR_W-1:0] fwdReg,
    output logic [DATA_W-1:0]     fwdData
`endif
);

    // One pipeline entry as carried from MEM to WB.
    typedef struct packed {
        logic                  hit;
        logic [DATA_W-1:0]     readData;
        logic [DATA_W-1:0]     aluResult;
        logic [REG_ADDR_W-1:0] writeReg;
        logic                  regWrite;
        logic                  memToReg;
    } wbEntry_t;

    wbEntry_t inEntry;
    wbEntry_t headEntry;
    wbEntry_t skidEntry;

    logic headValid;
    logic skidValid;

    logic accept;
    logic pop;

    logic headLoadIn;
    logic headLoadSkid;
    logic skidLoad;
    logic headValidNext;
    logic skidValidNext;

    assign inEntry = '{
        hit:       hit,
        readData:  readData,
        aluResult: ALUResult,
        writeReg:  writeReg,
        regWrite:  RegWrite,
        memToReg:  MemToReg
    };

    // Handshake terms; both are evaluated against the same rising edge.
    assign in_ready = !skidValid;
    assign accept   = in_valid & in_ready;
    assign pop      = headValid & out_ready;

    // Decide where each entry moves at the coming edge; flush overrides all.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        headLoadIn    = 1'b0;
        headLoadSkid  = 1'b0;
        skidLoad      = 1'b0;
        headValidNext = headValid;
        skidValidNext = skidValid;

        if (flush) begin
            // The handshake still completes, but everything is dropped.
            headValidNext = 1'b0;
            skidValidNext = 1'b0;
        end else if (!headValid) begin
            // Empty stage: skid is necessarily empty too.
            if (accept) begin
                headLoadIn    = 1'b1;
                headValidNext = 1'b1;
            end
        end else if (pop) begin
            if (skidValid) begin
                // Overflow entry moves up; in_ready was low, so no accept.
                headLoadSkid  = 1'b1;
                skidValidNext = 1'b0;
            end else if (accept) begin
                // Replace the head in the same cycle: no bubble.
                headLoadIn    = 1'b1;
            end else begin
                headValidNext = 1'b0;
            end
        end else if (accept) begin
            // Head stalled: park the new entry in the skid slot.
            skidLoad      = 1'b1;
            skidValidNext = 1'b1;
        end
    end

    // Occupancy flags; reset drops any in-flight entries immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            headValid <= 1'b0;
            skidValid <= 1'b0;
        end else begin
            headValid <= headValidNext;
            skidValid <= skidValidNext;
        end
    end

    // Head payload loads only when written, so outputs hold during a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: payload flops are reset even though valid qualifies them, so
        // writeback never sees X straight after reset.
        if (!rst_n) begin
            headEntry <= '0;
        end else if (headLoadSkid) begin
            headEntry <= skidEntry;
        end else if (headLoadIn) begin
            headEntry <= inEntry;
        end
    end

    // Skid payload captures the overflow entry while the head is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skidEntry <= '0;
        end else if (skidLoad) begin
            skidEntry <= inEntry;
        end
    end

    // Writeback outputs come from the head; a bubble never writes.
    assign out_valid     = headValid;
    assign hit_OUT       = headEntry.hit;
    assign readData_OUT  = headEntry.readData;
    assign ALUResult_OUT = headEntry.aluResult;
    assign writeReg_OUT  = headEntry.writeReg;
    assign MemToReg_OUT  = headEntry.memToReg;
    assign RegWrite_OUT  = headValid & headEntry.regWrite;

`ifdef MEM_WB_FWD_EN
    // Forwarding view of the head entry; register x0 is never forwarded.
    assign fwdValid = headValid & headEntry.regWrite & (headEntry.writeReg != '0);
    assign fwdReg   = headEntry.writeReg;
    assign fwdData  = headEntry.memToReg ? headEntry.readData : headEntry.aluResult;
`endif

endmodule
